program_sequencer: RTL and testbench

//  Generates the program-memory address feeding instruction_decoder; pc tracks the address of the instruction in ir.

---
 rtl/salt_pkg.sv | 24 ++
 rtl/seq_branch_trace.sv | 54 +++++
 rtl/program_sequencer.sv | 157 +++++++++++++++
 tb/tb_program_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/salt_pkg.sv
// Shared types and constants for the program sequencer slice.
// Holds the debug run-control state encoding, the NOP opcode the top level
// injects while halted, the default program-memory address width and the
// zero pad that forms the low nibble of every jump target.
package salt_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        HALT       = 3'd1,
        STEP_FETCH = 3'd2,
        STEP_EXEC  = 3'd3,
        RESUME     = 3'd4
    } seq_state_t;

    localparam logic [7:0] NOP_OPCODE    = 8'hC8;
    localparam int         PM_AW_DEFAULT = 8;
    localparam logic [3:0] JMP_PAD       = 4'b0000;

    // Jump target: decoder nibble in the high half, low half padded with zeros.
    function automatic logic [7:0] jump_target(input logic [3:0] nibble);
        return {nibble, JMP_PAD};
    endfunction

endpackage

// File: rtl/seq_branch_trace.sv
// Circular trace of taken-branch source addresses.
// Only instantiated when SEQ_BRANCH_TRACE_EN is defined. Entry 0 on the read
// side is the newest write; reads past the number of valid entries return 0.
// DEPTH must be a power of two no larger than 7 so the 3-bit count can hold it.
module seq_branch_trace #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          sync_reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_pc,
    input  logic [1:0]    rd_idx,
    output logic [AW-1:0] rd_data,
    output logic [2:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_s;
    logic [2:0]    count_r;

    // Write taken-branch sources into the ring and keep a saturating fill count.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr_r <= '0;
            count_r  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_pc;
            wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            if (count_r != 3'(DEPTH)) begin
                count_r <= count_r + 3'd1;
            end
        end
    end

    // Newest-first read: walk back from the write pointer, blank unused slots.
    always_comb begin
        rd_ptr_s = wr_ptr_r - PW'(1'b1) - PW'(rd_idx);
        if ({1'b0, rd_idx} < count_r) begin
            rd_data = mem_r[rd_ptr_s];
        end else begin
            rd_data = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: drives the program-memory address for the instruction
// decoder, resolves jmp / jmp_nz against the ALU zero flag, and hosts the
// debug run-control FSM (halt / single-step / resume) that freezes pc and
// asks the top level to inject NOPs. pc is the address of the instruction
// currently in ir, so pc <= pm_addr on every edge.
// Optional feature: define SEQ_BRANCH_TRACE_EN to add a branch-source trace.
module program_sequencer
    import salt_pkg::*;
#(
    parameter int PM_AW       = PM_AW_DEFAULT,
    parameter int TRACE_DEPTH = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             jmp,
    input  logic             jmp_nz,
    input  logic [3:0]       ir_nibble,
    input  logic             dont_jmp,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             run_req,
    output logic [PM_AW-1:0] pm_addr,
    output logic [PM_AW-1:0] pc,
    output logic [7:0]       from_PS,
    output logic             nop_inject,
    output logic             halted,
    input  logic [1:0]       trace_rd_idx,
    output logic [PM_AW-1:0] trace_data,
    output logic [2:0]       trace_count
);

    seq_state_t       state_r;
    seq_state_t       state_nx_s;
    logic [PM_AW-1:0] pc_r;
    logic [PM_AW-1:0] pm_addr_s;
    logic [PM_AW-1:0] seq_s;
    logic [PM_AW-1:0] target_s;
    logic             taken_s;
    logic             nop_s;
    logic             halted_s;
    logic             trace_wr_s;

    // Sequential next address: jump target when taken, otherwise pc+1 (wraps).
    always_comb begin
        target_s = PM_AW'(jump_target(ir_nibble));
        taken_s  = jmp | (jmp_nz & ~dont_jmp);
        if (taken_s) begin
            seq_s = target_s;
        end else begin
            seq_s = pc_r + PM_AW'(1'b1);
        end
    end

    // Run-control next state, address select and NOP request; reset forces address 0.
    always_comb begin
        state_nx_s = state_r;
        pm_addr_s  = seq_s;
        nop_s      = 1'b0;
        trace_wr_s = 1'b0;
        case (state_r)
            RUN: begin
                pm_addr_s  = seq_s;
                nop_s      = halt_req;
                trace_wr_s = taken_s;
                if (halt_req) begin
                    state_nx_s = HALT;
                end else begin
                    state_nx_s = RUN;
                end
            end
            HALT: begin
                pm_addr_s = pc_r;
                nop_s     = 1'b1;
                if (run_req) begin
                    state_nx_s = RESUME;
                end else if (step_req) begin
                    state_nx_s = STEP_FETCH;
                end else begin
                    state_nx_s = HALT;
                end
            end
            STEP_FETCH: begin
                // Refetch the instruction at pc so the step executes it for real.
                pm_addr_s  = pc_r;
                nop_s      = 1'b0;
                state_nx_s = STEP_EXEC;
            end
            STEP_EXEC: begin
                pm_addr_s  = seq_s;
                nop_s      = 1'b1;
                trace_wr_s = taken_s;
                state_nx_s = HALT;
            end
            RESUME: begin
                pm_addr_s  = pc_r;
                nop_s      = 1'b0;
                state_nx_s = RUN;
            end
            default: begin
                pm_addr_s  = pc_r;
                nop_s      = 1'b0;
                state_nx_s = RUN;
            end
        endcase
        if (sync_reset) begin
            pm_addr_s  = '0;
            nop_s      = 1'b0;
            trace_wr_s = 1'b0;
        end else begin
            trace_wr_s = trace_wr_s;
        end
        halted_s = (state_r == HALT) & ~sync_reset;
    end

    // State and program counter registers; pc always follows the fetched address.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r <= RUN;
            pc_r    <= '0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pm_addr_s;
        end
    end

    assign pm_addr    = pm_addr_s;
    assign pc         = pc_r;
    assign nop_inject = nop_s;
    assign halted     = halted_s;

    if (PM_AW >= 8) begin : g_tap_trunc
        assign from_PS = pc_r[7:0];
    end else begin : g_tap_ext
        assign from_PS = {{(8 - PM_AW){1'b0}}, pc_r};
    end

`ifdef SEQ_BRANCH_TRACE_EN
    seq_branch_trace #(
        .AW    (PM_AW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .sync_reset (sync_reset),
        .wr_en      (trace_wr_s),
        .wr_pc      (pc_r),
        .rd_idx     (trace_rd_idx),
        .rd_data    (trace_data),
        .count      (trace_count)
    );
`else
    logic unused_trace_s;
    assign trace_data     = '0;
    assign trace_count    = 3'd0;
    assign unused_trace_s = ^{trace_rd_idx, trace_wr_s, TRACE_DEPTH[0]};
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: per-cycle directed vectors with
// hand-computed pc / pm_addr / nop_inject / halted, plus short hand-written
// sequences for re-halt after resume, reset during a step, and the trace.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       jmp, jmp_nz, dont_jmp;
    logic [3:0] ir_nibble;
    logic       halt_req, step_req, run_req;
    logic [7:0] pm_addr, pc, from_PS;
    logic       nop_inject, halted;
    logic [1:0] trace_rd_idx;
    logic [7:0] trace_data;
    logic [2:0] trace_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    program_sequencer #(.PM_AW(8), .TRACE_DEPTH(4)) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .ir_nibble    (ir_nibble),
        .dont_jmp     (dont_jmp),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .run_req      (run_req),
        .pm_addr      (pm_addr),
        .pc           (pc),
        .from_PS      (from_PS),
        .nop_inject   (nop_inject),
        .halted       (halted),
        .trace_rd_idx (trace_rd_idx),
        .trace_data   (trace_data),
        .trace_count  (trace_count)
    );

    typedef struct {
        logic       jmp;
        logic       jnz;
        logic [3:0] nib;
        logic       dz;
        logic       hr;
        logic       sr;
        logic       rr;
        logic [7:0] pc;
        logic [7:0] pm;
        logic       nop;
        logic       hlt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic j, jn, input logic [3:0] nib, input logic dz, hr, sr, rr,
                       input logic [7:0] epc, epm, input logic enop, ehlt);
        vec_t v;
        v.jmp = j;  v.jnz = jn; v.nib = nib; v.dz = dz;
        v.hr  = hr; v.sr  = sr; v.rr  = rr;
        v.pc  = epc; v.pm = epm; v.nop = enop; v.hlt = ehlt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic j, jn, input logic [3:0] nib, input logic dz, hr, sr, rr);
        jmp = j; jmp_nz = jn; ir_nibble = nib; dont_jmp = dz;
        halt_req = hr; step_req = sr; run_req = rr;
    endtask

    task automatic check_state(input string tag, input logic [7:0] epc, epm, input logic enop, ehlt);
        chk($sformatf("%s pc", tag), {24'd0, pc}, {24'd0, epc});
        chk($sformatf("%s from_PS", tag), {24'd0, from_PS}, {24'd0, epc});
        chk($sformatf("%s pm_addr", tag), {24'd0, pm_addr}, {24'd0, epm});
        chk($sformatf("%s nop_inject", tag), {31'd0, nop_inject}, {31'd0, enop});
        chk($sformatf("%s halted", tag), {31'd0, halted}, {31'd0, ehlt});
    endtask

    initial begin
        sync_reset   = 1'b1;
        trace_rd_idx = 2'd0;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Free run from reset: pm_addr leads pc by one.
        for (int i = 0; i < 5; i++) add(0, 0, 4'h0, 0, 0, 0, 0, 8'(i), 8'(i + 1), 0, 0);
        add(0, 1, 4'h3, 1, 0, 0, 0, 8'h05, 8'h06, 0, 0);   // jmp_nz suppressed
        add(0, 0, 4'h0, 0, 0, 0, 0, 8'h06, 8'h07, 0, 0);
        add(0, 1, 4'hA, 1, 0, 0, 0, 8'h07, 8'h08, 0, 0);   // zero flag set: fall through
        add(0, 1, 4'hA, 0, 0, 0, 0, 8'h08, 8'hA0, 0, 0);   // zero flag clear: taken
        add(1, 0, 4'h3, 0, 0, 0, 0, 8'hA0, 8'h30, 0, 0);   // unconditional jump
        add(1, 1, 4'hF, 1, 0, 0, 0, 8'h30, 8'hF0, 0, 0);   // jmp ignores the zero flag
        for (int i = 0; i < 16; i++) add(0, 0, 4'h0, 0, 0, 0, 0, 8'(8'hF0 + i), 8'(8'hF1 + i), 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 4'h0, 0, 0, 0, 0, 8'(i), 8'(i + 1), 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h04, 8'h05, 1, 0);   // halt request at pc=4
        add(0, 0, 4'h0, 0, 0, 0, 0, 8'h05, 8'h05, 1, 1);   // HALT, pc frozen
        add(0, 0, 4'h0, 0, 0, 1, 0, 8'h05, 8'h05, 1, 1);   // step request
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h05, 8'h05, 0, 0);   // STEP_FETCH ignores requests
        add(0, 0, 4'h0, 0, 0, 0, 0, 8'h05, 8'h06, 1, 0);   // STEP_EXEC
        add(0, 0, 4'h0, 0, 0, 1, 1, 8'h06, 8'h06, 1, 1);   // HALT, run beats step

        // Reset state.
        @(negedge clk);
        #1;
        check_state("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset trace_count", {29'd0, trace_count}, 32'd0);
        @(negedge clk);
        sync_reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].jmp, tbl[i].jnz, tbl[i].nib, tbl[i].dz, tbl[i].hr, tbl[i].sr, tbl[i].rr);
            #2;
            check_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].pm, tbl[i].nop, tbl[i].hlt);
            @(negedge clk);
        end

        // halt_req held through RESUME re-halts after one instruction.
        drive(0, 0, 4'h0, 0, 1, 0, 0);
        #2; check_state("resume", 8'h06, 8'h06, 1'b0, 1'b0);
        @(negedge clk);
        #2; check_state("rehalt_run", 8'h06, 8'h07, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        #2; check_state("rehalt_halt", 8'h07, 8'h07, 1'b1, 1'b1);
        @(negedge clk);

        // Reset in the middle of a single step.
        drive(0, 0, 4'h0, 0, 0, 1, 0);
        #2; check_state("step_req", 8'h07, 8'h07, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        sync_reset = 1'b1;
        #2; check_state("reset_in_step", 8'h07, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        sync_reset = 1'b0;
        #2; check_state("after_reset", 8'h00, 8'h01, 1'b0, 1'b0);
        @(negedge clk);

        // Three taken branches from sources 0x01, 0x10, 0x20.
        drive(1, 0, 4'h1, 0, 0, 0, 0);
        #2; check_state("br1", 8'h01, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 0, 4'h2, 0, 0, 0, 0);
        #2; check_state("br2", 8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1, 4'h3, 0, 0, 0, 0);
        #2; check_state("br3", 8'h20, 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        #2; check_state("post_br", 8'h30, 8'h31, 1'b0, 1'b0);
`ifdef SEQ_BRANCH_TRACE_EN
        chk("trace_count", {29'd0, trace_count}, 32'd3);
        trace_rd_idx = 2'd0; #1; chk("trace idx0", {24'd0, trace_data}, 32'h20);
        trace_rd_idx = 2'd1; #1; chk("trace idx1", {24'd0, trace_data}, 32'h10);
        trace_rd_idx = 2'd2; #1; chk("trace idx2", {24'd0, trace_data}, 32'h01);
        trace_rd_idx = 2'd3; #1; chk("trace idx3", {24'd0, trace_data}, 32'h00);
`else
        chk("trace_count off", {29'd0, trace_count}, 32'd0);
        trace_rd_idx = 2'd0; #1; chk("trace idx0 off", {24'd0, trace_data}, 32'h00);
        trace_rd_idx = 2'd2; #1; chk("trace idx2 off", {24'd0, trace_data}, 32'h00);
`endif
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
